// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forward-select encodings for the E-stage ALU operand muxes
//   - redirect sequencer state encoding
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } seq_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_param_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the count
//   clr   - synchronous clear, has priority over inc
//   inc   - increment request, ignored once the count is all-ones
//   count - current count value
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_r;

    // Count register: clear beats increment, and the value sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (inc && (count_r != {CW{1'b1}})) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: hazard and forwarding controller for a 5-stage MIPS pipeline.
//   Inputs : RsD/RtD, RsE/RtE source registers; WriteReg*/RegWrite* per stage;
//            MemtoRegE/M load flags; BranchD, PCSrcD redirect request; CntClr.
//   Outputs: StallF/StallD, FlushD/FlushE pipeline control; ForwardAD/BD
//            D-stage forward from M; ForwardAE/BE E-stage operand select;
//            RedirectBusy while draining fetch after a redirect;
//            StallCount/RedirectCount saturating performance counters.
//   Forwarding and stall outputs are combinational from inputs plus state.
module hazard_ctrl_param
    import hazard_pkg::*;
#(
    parameter int AW             = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int CW             = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] RsD,
    input  logic [AW-1:0] RtD,
    input  logic [AW-1:0] RsE,
    input  logic [AW-1:0] RtE,
    input  logic [AW-1:0] WriteRegE,
    input  logic [AW-1:0] WriteRegM,
    input  logic [AW-1:0] WriteRegW,
    input  logic          RegWriteE,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          MemtoRegM,
    input  logic          BranchD,
    input  logic          PCSrcD,
    input  logic          CntClr,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          RedirectBusy,
    output logic [CW-1:0] StallCount,
    output logic [CW-1:0] RedirectCount
);

    localparam bit         HAS_PENALTY = (BRANCH_PENALTY > 0);
    localparam logic [3:0] PEN_LOAD    = HAS_PENALTY ? 4'(BRANCH_PENALTY - 1) : 4'd0;

    // A write to register 0 is never a real producer, so it never matches.
    function automatic logic reg_match(input logic we, input logic [AW-1:0] wr,
                                       input logic [AW-1:0] r);
        return we && (wr != {AW{1'b0}}) && (r == wr);
    endfunction

    seq_state_e state_r;
    logic [3:0] pcnt_r;

    logic       mE_rsd_s, mE_rtd_s, mM_rsd_s, mM_rtd_s;
    logic       mM_rse_s, mW_rse_s, mM_rte_s, mW_rte_s;
    logic       lwstall_s, brstall_s, dstall_s;
    logic       accept_s, stall_inc_s;

    assign mE_rsd_s = reg_match(RegWriteE, WriteRegE, RsD);
    assign mE_rtd_s = reg_match(RegWriteE, WriteRegE, RtD);
    assign mM_rsd_s = reg_match(RegWriteM, WriteRegM, RsD);
    assign mM_rtd_s = reg_match(RegWriteM, WriteRegM, RtD);
    assign mM_rse_s = reg_match(RegWriteM, WriteRegM, RsE);
    assign mW_rse_s = reg_match(RegWriteW, WriteRegW, RsE);
    assign mM_rte_s = reg_match(RegWriteM, WriteRegM, RtE);
    assign mW_rte_s = reg_match(RegWriteW, WriteRegW, RtE);

    // A branch compares in D, so it must also wait for a load still in M.
    assign lwstall_s = MemtoRegE && (mE_rsd_s || mE_rtd_s);
    assign brstall_s = BranchD && (mE_rsd_s || mE_rtd_s ||
                                   (MemtoRegM && (mM_rsd_s || mM_rtd_s)));
    assign dstall_s  = lwstall_s || brstall_s;

    // Redirects are only taken once the branch operands are ready.
    assign accept_s    = (state_r == IDLE) && !dstall_s && PCSrcD;
    assign stall_inc_s = (state_r == IDLE) && dstall_s;

    // Redirect sequencer: DRAIN holds fetch for BRANCH_PENALTY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pcnt_r  <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && HAS_PENALTY) begin
                        state_r <= DRAIN;
                        pcnt_r  <= PEN_LOAD;
                    end else begin
                        state_r <= IDLE;
                        pcnt_r  <= pcnt_r;
                    end
                end
                DRAIN: begin
                    if (pcnt_r == 4'd0) begin
                        state_r <= IDLE;
                        pcnt_r  <= 4'd0;
                    end else begin
                        state_r <= DRAIN;
                        pcnt_r  <= pcnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pcnt_r  <= 4'd0;
                end
            endcase
        end
    end

    // Pipeline control and forwarding; everything is held low during reset.
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        RedirectBusy = 1'b0;
        ForwardAD    = 1'b0;
        ForwardBD    = 1'b0;
        ForwardAE    = FWD_NONE;
        ForwardBE    = FWD_NONE;
        if (!rst_n) begin
            StallF = 1'b0;
        end else begin
            ForwardAD = mM_rsd_s;
            ForwardBD = mM_rtd_s;
            if (mM_rse_s) begin
                ForwardAE = FWD_MEM;
            end else if (mW_rse_s) begin
                ForwardAE = FWD_WB;
            end else begin
                ForwardAE = FWD_NONE;
            end
            if (mM_rte_s) begin
                ForwardBE = FWD_MEM;
            end else if (mW_rte_s) begin
                ForwardBE = FWD_WB;
            end else begin
                ForwardBE = FWD_NONE;
            end
            case (state_r)
                IDLE: begin
                    if (dstall_s) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (PCSrcD) begin
                        FlushD = 1'b1;
                    end else begin
                        FlushD = 1'b0;
                    end
                end
                DRAIN: begin
                    StallF       = 1'b1;
                    FlushD       = 1'b1;
                    RedirectBusy = 1'b1;
                end
                default: begin
                    StallF = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (stall_inc_s),
        .count (StallCount)
    );

    sat_counter #(.CW(CW)) u_redir_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (accept_s),
        .count (RedirectCount)
    );

endmodule : hazard_ctrl_param

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed self-checking bench for hazard_ctrl_param
// (AW=5, BRANCH_PENALTY=2, CW=4 so saturation is reachable quickly).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_ctrl_param;

    logic       clk, rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, CntClr;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, RedirectBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCount, RedirectCount;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_param #(.AW(5), .BRANCH_PENALTY(2), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .CntClr(CntClr), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RedirectBusy(RedirectBusy),
        .StallCount(StallCount), .RedirectCount(RedirectCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; PCSrcD = 1'b0; CntClr = 1'b0;
    endtask

    // Packs the control outputs as {StallF,StallD,FlushD,FlushE,RedirectBusy}.
    function automatic logic [4:0] ctl();
        return {StallF, StallD, FlushD, FlushE, RedirectBusy};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        // Hazard and forward conditions present while in reset must be masked.
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        RegWriteM = 1'b1; WriteRegM = 5'd6; RsE = 5'd6; RtD = 5'd6;
        #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rst_ctl: got %b want %b", ctl(), 5'b00000); end
        checks++; if ({ForwardAE, ForwardAD, ForwardBD} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b want %b", {ForwardAE, ForwardAD, ForwardBD}, 4'b0000); end
        @(posedge clk); #1;
        checks++; if ({StallCount, RedirectCount} !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h want %h", {StallCount, RedirectCount}, 8'h00); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        #1;
        checks++; if (ctl() !== 5'b11010) begin errors++; $display("FAIL lu_ctl: got %b want %b", ctl(), 5'b11010); end
        checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL lu_cnt0: got %0d want %0d", StallCount, 0); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_release: got %b want %b", ctl(), 5'b00000); end
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL lu_cnt1: got %0d want %0d", StallCount, 1); end
        // Load target in RtD, but RegWriteE low: no stall.
        MemtoRegE = 1'b1; RegWriteE = 1'b0; WriteRegE = 5'd8; RtD = 5'd8;
        #1;
        checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL lu_nowe: got %b want %b", StallF, 1'b0); end
    endtask

    task automatic test_forward_gating();
        @(negedge clk);
        clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 5'd0; RsE = 5'd0; RtE = 5'd0;
        #1;
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_r0: got %b want %b", {ForwardAE, ForwardBE}, 4'b0000); end
        RsE = 5'd9; RsD = 5'd9; RegWriteM = 1'b0; WriteRegM = 5'd9;
        RegWriteW = 1'b1; WriteRegW = 5'd9;
        #1;
        checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b want %b", ForwardAE, 2'b01); end
        checks++; if (ForwardAD !== 1'b0) begin errors++; $display("FAIL fwd_ad_nowe: got %b want %b", ForwardAD, 1'b0); end
        RegWriteM = 1'b1;
        #1;
        checks++; if ({ForwardAE, ForwardAD} !== 3'b101) begin errors++; $display("FAIL fwd_mem: got %b want %b", {ForwardAE, ForwardAD}, 3'b101); end
        checks++; if ({ForwardBE, ForwardBD} !== 3'b000) begin errors++; $display("FAIL fwd_b_idle: got %b want %b", {ForwardBE, ForwardBD}, 3'b000); end
    endtask

    task automatic test_double_match();
        @(negedge clk);
        clear_inputs();
        RsE = 5'd5; RtE = 5'd5; RtD = 5'd5;
        RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
        #1;
        checks++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin errors++; $display("FAIL dbl_fwd: got %b want %b", {ForwardAE, ForwardBE}, 4'b1010); end
        checks++; if ({ForwardAD, ForwardBD} !== 2'b01) begin errors++; $display("FAIL dbl_fwd_d: got %b want %b", {ForwardAD, ForwardBD}, 2'b01); end
        RegWriteM = 1'b0;
        #1;
        checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL dbl_wb_only: got %b want %b", ForwardBE, 2'b01); end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        clear_inputs();
        PCSrcD = 1'b1;
        #1;
        checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL rd_accept: got %b want %b", ctl(), 5'b00100); end
        // Drain cycle 1: PCSrcD still high must be ignored.
        @(negedge clk); #1;
        checks++; if (ctl() !== 5'b10101) begin errors++; $display("FAIL rd_drain1: got %b want %b", ctl(), 5'b10101); end
        checks++; if (RedirectCount !== 4'd1) begin errors++; $display("FAIL rd_cnt1: got %0d want %0d", RedirectCount, 1); end
        // Drain cycle 2: a load-use hazard is also ignored.
        @(negedge clk);
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7;
        #1;
        checks++; if (ctl() !== 5'b10101) begin errors++; $display("FAIL rd_drain2: got %b want %b", ctl(), 5'b10101); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rd_idle: got %b want %b", ctl(), 5'b00000); end
        checks++; if ({StallCount, RedirectCount} !== {4'd1, 4'd1}) begin errors++; $display("FAIL rd_cnts: got %h want %h", {StallCount, RedirectCount}, {4'd1, 4'd1}); end
    endtask

    task automatic test_branch_stall();
        // Branch waiting on a load in M.
        @(negedge clk);
        clear_inputs();
        BranchD = 1'b1; RsD = 5'd4; MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd4;
        #1;
        checks++; if (ctl() !== 5'b11010) begin errors++; $display("FAIL br_mload: got %b want %b", ctl(), 5'b11010); end
        @(negedge clk);
        MemtoRegM = 1'b0;
        #1;
        checks++; if ({StallF, ForwardAD} !== 2'b01) begin errors++; $display("FAIL br_malu: got %b want %b", {StallF, ForwardAD}, 2'b01); end
        checks++; if (StallCount !== 4'd2) begin errors++; $display("FAIL br_cnt2: got %0d want %0d", StallCount, 2); end
        // ALU result in E for RsD: stall and ignore the redirect.
        @(negedge clk);
        clear_inputs();
        BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; PCSrcD = 1'b1;
        #1;
        checks++; if (ctl() !== 5'b11010) begin errors++; $display("FAIL br_ealu: got %b want %b", ctl(), 5'b11010); end
        @(negedge clk);
        RegWriteE = 1'b0;
        #1;
        checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL br_accept: got %b want %b", ctl(), 5'b00100); end
        checks++; if ({StallCount, RedirectCount} !== {4'd3, 4'd1}) begin errors++; $display("FAIL br_cnts: got %h want %h", {StallCount, RedirectCount}, {4'd3, 4'd1}); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (RedirectBusy !== 1'b1) begin errors++; $display("FAIL br_busy: got %b want %b", RedirectBusy, 1'b1); end
        checks++; if (RedirectCount !== 4'd2) begin errors++; $display("FAIL br_rcnt2: got %0d want %0d", RedirectCount, 2); end
    endtask

    // Entered while in DRAIN cycle 1 from test_branch_stall.
    task automatic test_reset_mid_drain();
        #2;
        RsE = 5'd6; RegWriteM = 1'b1; WriteRegM = 5'd6;
        rst_n = 1'b0;
        #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rmd_ctl: got %b want %b", ctl(), 5'b00000); end
        checks++; if ({ForwardAE, StallCount, RedirectCount} !== 10'd0) begin errors++; $display("FAIL rmd_fwdcnt: got %h want %h", {ForwardAE, StallCount, RedirectCount}, 10'd0); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL rmd_idle: got %b want %b", ctl(), 5'b00000); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (StallCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want %0d", StallCount, 15); end
        CntClr = 1'b1;
        @(negedge clk); #1;
        checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d want %0d", StallCount, 0); end
        CntClr = 1'b0;
        @(negedge clk); #1;
        checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL sat_restart: got %0d want %0d", StallCount, 1); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward_gating();
        test_double_match();
        test_redirect();
        test_branch_stall();
        test_reset_mid_drain();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_ctrl_param

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It generates forwarding selects for the D and E stages, load-use and branch-operand stalls, and a configurable PC-redirect penalty sequencer. It sits beside the datapath and drives its stall/flush pins. Compared with the previous unit it adds:
- register-0 and RegWrite qualification on every match;
- a decode-stage flush output;
- saturating stall and redirect performance counters.

Parameters:
AW, 5, register-address width
BRANCH_PENALTY, 2, extra fetch-bubble cycles after an accepted redirect (legal 0..15)
CW, 32, performance-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsD, RtD  in  AW  decode source registers
RsE, RtE  in  AW  execute source registers
WriteRegE, WriteRegM, WriteRegW  in  AW  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1  write enable per stage
MemtoRegE, MemtoRegM  in  1  stage holds a load
BranchD  in  1  decode holds a branch comparing in D
PCSrcD  in  1  branch taken / redirect request from D
CntClr  in  1  synchronous clear of both counters
StallF, StallD  out  1  hold PC / IF-ID register
FlushD, FlushE  out  1  bubble into IF-ID / ID-EX register
ForwardAD, ForwardBD  out  1  D-stage comparator forward from M
ForwardAE, ForwardBE  out  2  E-stage ALU operand select
RedirectBusy  out  1  sequencer in DRAIN
StallCount, RedirectCount  out  CW  performance counters

Behaviour:
- Match definitions:
  - matchX(r) = RegWriteX & (WriteRegX != 0) & (r == WriteRegX), for X in E, M, W.
  - Register 0 never matches.
- Forwarding (combinational):
  - ForwardAE = 2'b10 if matchM(RsE); else 2'b01 if matchW(RsE); else 2'b00. ForwardBE uses RtE the same way. M has priority over W.
  - ForwardAD = matchM(RsD); ForwardBD = matchM(RtD).
- Stall conditions:
  - lwstall = MemtoRegE & (matchE(RsD) | matchE(RtD)).
  - brstall = BranchD & (matchE(RsD) | matchE(RtD) | (MemtoRegM & (matchM(RsD) | matchM(RtD)))).
  - dstall = lwstall | brstall.
- Sequencer FSM, states IDLE and DRAIN, with a 4-bit down-counter pcnt:
  - IDLE, dstall=1: StallF=StallD=FlushE=1, FlushD=0. PCSrcD is ignored because the branch operands are not ready.
  - IDLE, dstall=0, PCSrcD=1 (redirect accepted): FlushD=1 and the redirect counter increments.
    - If BRANCH_PENALTY>0: next state DRAIN, pcnt <= BRANCH_PENALTY-1.
    - If BRANCH_PENALTY=0: stay in IDLE.
  - IDLE, otherwise: all stall/flush outputs 0.
  - DRAIN: StallF=1, FlushD=1, StallD=0, FlushE=0, RedirectBusy=1. PCSrcD and dstall are ignored, since decode holds a bubble.
    - pcnt decrements each cycle; at pcnt==0, next state is IDLE.
    - DRAIN therefore lasts exactly BRANCH_PENALTY cycles.
- Counters:
  - StallCount +1 each cycle with IDLE & dstall.
  - RedirectCount +1 on each accepted redirect.
  - Both saturate at all-ones and never wrap.
  - CntClr wins over a simultaneous increment; the counter reads 0 the next cycle.
- Reset:
  - rst_n low asynchronously forces IDLE, pcnt=0 and counters=0.
  - While rst_n is low, StallF, StallD, FlushD, FlushE, RedirectBusy, ForwardAD/BD and ForwardAE/BE are forced to 0.
  - Reset asserted mid-DRAIN aborts the drain immediately.
- Latency: forwarding and stall outputs are combinational from the inputs plus the current state. State and counters update on the rising clk edge.

Decomposition:
- Package hazard_pkg:
  - forward-select constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - sequencer state enum {IDLE, DRAIN}.
- Sub-module sat_counter (parameter CW; ports clk, rst_n, clr, inc, count), instantiated twice for the counters.

Test Plan:
- Load-use: E = lw to $8 (MemtoRegE=1, RegWriteE=1, WriteRegE=8), RsD=8 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0, StallCount 0->1.
- Zero register / write-enable gating: WriteRegM=0 with RegWriteM=1 and RsE=0 -> ForwardAE=00. RsE=9 with WriteRegM=9, RegWriteM=0, and matchW(9) true -> ForwardAE=01.
- Double match: RsE=RtE=5, matchM(5) and matchW(5) both true -> ForwardAE=ForwardBE=10.
- Redirect, BRANCH_PENALTY=2: PCSrcD=1 in IDLE -> FlushD=1 that cycle, then 2 cycles of StallF=FlushD=RedirectBusy=1, then IDLE. A PCSrcD pulse during DRAIN has no effect. RedirectCount=1.
- Branch-operand stall: BranchD=1, RsD=3, E writes $3 via ALU, PCSrcD=1 -> stall asserted, redirect ignored. The next cycle (match gone) accepts the redirect.
- Reset and saturation: rst_n low during DRAIN cycle 1 -> all outputs 0 immediately, state IDLE after release. CW=4 with 20 stall cycles -> StallCount holds 15; CntClr -> 0.
